// File: rtl/panda_counter.sv
// Up/down event counter driven by the panda_pulse output train.
// Trigger rising edges add or subtract STEP; reports signed overflow as a carry pulse and a sticky flag.
module panda_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             trigger_i,
  input  logic             dir_i,
  input  logic [CNT_W-1:0] START,
  input  logic [CNT_W-1:0] STEP,
  input  logic             FORCE_RST,
  output logic [CNT_W-1:0] count_o,
  output logic             carry_o,
  output logic             ERR_OVERFLOW,
  output logic [CNT_W-1:0] TRIG_CNT
);

  logic             enable_prev_q, trigger_prev_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] trig_cnt_q, trig_cnt_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;

  logic             enable_rise, trigger_rise;
  logic [CNT_W-1:0] addend;
  logic [CNT_W:0]   sum;
  logic             ovf;

  assign enable_rise  = enable_i & ~enable_prev_q;
  assign trigger_rise = trigger_i & ~trigger_prev_q;

  // The negated STEP is sign-extended as a CNT_W-bit value, so the most negative
  // STEP stays a negative addend and its overflow shows up in the top two sum bits.
  always_comb begin
    addend = dir_i ? ({CNT_W{1'b0}} - STEP) : STEP;
    sum    = {count_q[CNT_W-1], count_q} + {addend[CNT_W-1], addend};
    ovf    = sum[CNT_W] ^ sum[CNT_W-1];
  end

  always_comb begin
    count_d    = count_q;
    trig_cnt_d = trig_cnt_q;
    carry_d    = 1'b0;
    err_d      = err_q;
    if (FORCE_RST) begin
      count_d    = START;
      trig_cnt_d = '0;
      err_d      = 1'b0;
    end else if (enable_rise) begin
      count_d    = START;
      trig_cnt_d = '0;
    end else if (trigger_rise && enable_i) begin
      count_d    = sum[CNT_W-1:0];
      trig_cnt_d = trig_cnt_q + 1'b1;
      carry_d    = ovf;
      err_d      = err_q | ovf;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      enable_prev_q  <= 1'b0;
      trigger_prev_q <= 1'b0;
      count_q        <= '0;
      trig_cnt_q     <= '0;
      carry_q        <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      enable_prev_q  <= enable_i;
      trigger_prev_q <= trigger_i;
      count_q        <= count_d;
      trig_cnt_q     <= trig_cnt_d;
      carry_q        <= carry_d;
      err_q          <= err_d;
    end
  end

  assign count_o      = count_q;
  assign carry_o      = carry_q;
  assign ERR_OVERFLOW = err_q;
  assign TRIG_CNT     = trig_cnt_q;

endmodule

// File: tb/tb_panda_counter.sv
// Self-checking bench for panda_counter: directed scenarios plus a randomised up/down run,
// with expected counts queued when a trigger is driven and compared after the clock edge.
module tb_panda_counter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_i, enable_i, trigger_i, dir_i, FORCE_RST;
  logic [W-1:0] START, STEP;
  logic [W-1:0] count_o, TRIG_CNT;
  logic         carry_o, ERR_OVERFLOW;

  int           pass_cnt  = 0;
  int           total_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_c_q[$];

  panda_counter #(.CNT_W(W)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .trigger_i(trigger_i),
    .dir_i(dir_i), .START(START), .STEP(STEP), .FORCE_RST(FORCE_RST),
    .count_o(count_o), .carry_o(carry_o), .ERR_OVERFLOW(ERR_OVERFLOW), .TRIG_CNT(TRIG_CNT)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] s, input logic [W-1:0] st);
    START    = s;
    STEP     = st;
    enable_i = 1'b0;
    step();
    enable_i = 1'b1;
    step();
  endtask

  task automatic drive_pulse(input logic d, input logic [W-1:0] exp_cnt, input logic exp_c);
    dir_i     = d;
    trigger_i = 1'b1;
    exp_q.push_back(exp_cnt);
    exp_c_q.push_back(exp_c);
    step();
  endtask

  task automatic release_trig();
    trigger_i = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_i = 1'b1; enable_i = 1'b0; trigger_i = 1'b0; dir_i = 1'b0; FORCE_RST = 1'b0;
    START = 32'd77; STEP = 32'd1;
    step(); step();
    rst_i = 1'b0;
    step();
    total_cnt++; if (count_o !== '0) $display("FAIL reset_count: got %h expected 0", count_o); else pass_cnt++;
    total_cnt++; if (carry_o !== 1'b0) $display("FAIL reset_carry: got %b expected 0", carry_o); else pass_cnt++;
    total_cnt++; if (ERR_OVERFLOW !== 1'b0) $display("FAIL reset_err: got %b expected 0", ERR_OVERFLOW); else pass_cnt++;
    total_cnt++; if (TRIG_CNT !== '0) $display("FAIL reset_trig: got %0d expected 0", TRIG_CNT); else pass_cnt++;
  endtask

  task automatic test_up_count();
    logic [W-1:0] e;
    logic         ec;
    load(32'd10, 32'd5);
    total_cnt++; if (count_o !== 32'd10) $display("FAIL up_load: got %0d expected 10", count_o); else pass_cnt++;
    for (int i = 1; i <= 4; i++) begin
      drive_pulse(1'b0, 32'(10 + 5 * i), 1'b0);
      e = exp_q.pop_front(); ec = exp_c_q.pop_front();
      total_cnt++; if (count_o !== e) $display("FAIL up_count: got %0d expected %0d", count_o, e); else pass_cnt++;
      total_cnt++; if (carry_o !== ec) $display("FAIL up_carry: got %b expected %b", carry_o, ec); else pass_cnt++;
      release_trig();
    end
    total_cnt++; if (TRIG_CNT !== 32'd4) $display("FAIL up_trig: got %0d expected 4", TRIG_CNT); else pass_cnt++;
  endtask

  task automatic test_down_dir();
    logic [W-1:0] e;
    logic         dirs[3] = '{1'b1, 1'b1, 1'b0};
    int           vals[3] = '{-3, -6, -3};
    load(32'd0, 32'd3);
    for (int i = 0; i < 3; i++) begin
      drive_pulse(dirs[i], 32'(vals[i]), 1'b0);
      e = exp_q.pop_front(); void'(exp_c_q.pop_front());
      total_cnt++; if (count_o !== e) $display("FAIL down_count: got %0d expected %0d", $signed(count_o), $signed(e)); else pass_cnt++;
      release_trig();
    end
    total_cnt++; if (TRIG_CNT !== 32'd3) $display("FAIL down_trig: got %0d expected 3", TRIG_CNT); else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [W-1:0] e;
    logic         ec;
    logic [W-1:0] vals[3] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0001};
    logic         cars[3] = '{1'b0, 1'b1, 1'b0};
    load(32'h7FFF_FFFE, 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive_pulse(1'b0, vals[i], cars[i]);
      e = exp_q.pop_front(); ec = exp_c_q.pop_front();
      total_cnt++; if (count_o !== e) $display("FAIL ovf_count: got %h expected %h", count_o, e); else pass_cnt++;
      total_cnt++; if (carry_o !== ec) $display("FAIL ovf_carry: got %b expected %b", carry_o, ec); else pass_cnt++;
      release_trig();
      total_cnt++; if (carry_o !== 1'b0) $display("FAIL ovf_carry_width: got %b expected 0", carry_o); else pass_cnt++;
      total_cnt++; if (ERR_OVERFLOW !== (i > 0)) $display("FAIL ovf_err: got %b expected %b", ERR_OVERFLOW, i > 0); else pass_cnt++;
    end
  endtask

  task automatic test_underflow_min_step();
    logic [W-1:0] e;
    logic         ec;
    START = 32'hFFFF_FFFF; STEP = 32'h8000_0000;
    FORCE_RST = 1'b1;
    step();
    FORCE_RST = 1'b0;
    total_cnt++; if (ERR_OVERFLOW !== 1'b0) $display("FAIL unf_err_clear: got %b expected 0", ERR_OVERFLOW); else pass_cnt++;
    total_cnt++; if (count_o !== 32'hFFFF_FFFF) $display("FAIL unf_load: got %h expected ffffffff", count_o); else pass_cnt++;
    drive_pulse(1'b1, 32'h7FFF_FFFF, 1'b1);
    e = exp_q.pop_front(); ec = exp_c_q.pop_front();
    total_cnt++; if (count_o !== e) $display("FAIL unf_count: got %h expected %h", count_o, e); else pass_cnt++;
    total_cnt++; if (carry_o !== ec) $display("FAIL unf_carry: got %b expected %b", carry_o, ec); else pass_cnt++;
    total_cnt++; if (ERR_OVERFLOW !== 1'b1) $display("FAIL unf_err: got %b expected 1", ERR_OVERFLOW); else pass_cnt++;
    release_trig();
  endtask

  task automatic test_simul_enable();
    enable_i = 1'b0;
    step();
    START = 32'd100; STEP = 32'd9;
    enable_i = 1'b1; trigger_i = 1'b1; dir_i = 1'b0;
    step();
    total_cnt++; if (count_o !== 32'd100) $display("FAIL simul_en_count: got %0d expected 100", count_o); else pass_cnt++;
    total_cnt++; if (TRIG_CNT !== 32'd0) $display("FAIL simul_en_trig: got %0d expected 0", TRIG_CNT); else pass_cnt++;
    release_trig();
  endtask

  task automatic test_force_rst();
    load(32'd40, 32'd7);
    total_cnt++; if (count_o !== 32'd40 || ERR_OVERFLOW !== 1'b1) $display("FAIL force_pre: got %0d/%b expected 40/1", count_o, ERR_OVERFLOW); else pass_cnt++;
    START = 32'd5;
    FORCE_RST = 1'b1; trigger_i = 1'b1; dir_i = 1'b0;
    step();
    FORCE_RST = 1'b0;
    total_cnt++; if (count_o !== 32'd5) $display("FAIL force_count: got %0d expected 5", count_o); else pass_cnt++;
    total_cnt++; if (TRIG_CNT !== 32'd0) $display("FAIL force_trig: got %0d expected 0", TRIG_CNT); else pass_cnt++;
    total_cnt++; if (ERR_OVERFLOW !== 1'b0) $display("FAIL force_err: got %b expected 0", ERR_OVERFLOW); else pass_cnt++;
    release_trig();
  endtask

  task automatic test_step_zero();
    load(32'd123, 32'd0);
    drive_pulse(1'b0, 32'd123, 1'b0);
    void'(exp_c_q.pop_front());
    total_cnt++; if (count_o !== exp_q[0]) $display("FAIL step0_count: got %0d expected %0d", count_o, exp_q[0]); else pass_cnt++;
    void'(exp_q.pop_front());
    total_cnt++; if (TRIG_CNT !== 32'd1 || carry_o !== 1'b0) $display("FAIL step0_trig: got %0d/%b expected 1/0", TRIG_CNT, carry_o); else pass_cnt++;
    release_trig();
  endtask

  task automatic test_disable_reset();
    load(32'd0, 32'd1);
    drive_pulse(1'b0, 32'd1, 1'b0);
    void'(exp_c_q.pop_front());
    total_cnt++; if (count_o !== exp_q[0]) $display("FAIL dis_first: got %0d expected %0d", count_o, exp_q[0]); else pass_cnt++;
    void'(exp_q.pop_front());
    release_trig();
    enable_i = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      trigger_i = 1'b1; step();
      release_trig();
      total_cnt++; if (count_o !== 32'd1 || TRIG_CNT !== 32'd1) $display("FAIL dis_hold: got %0d/%0d expected 1/1", count_o, TRIG_CNT); else pass_cnt++;
    end
    load(32'd0, 32'd1);
    trigger_i = 1'b1; step(); release_trig();
    trigger_i = 1'b1; step(); release_trig();
    total_cnt++; if (count_o !== 32'd2) $display("FAIL rst_pre: got %0d expected 2", count_o); else pass_cnt++;
    rst_i = 1'b1;
    step();
    total_cnt++; if (count_o !== '0 || TRIG_CNT !== '0 || carry_o !== 1'b0) $display("FAIL rst_mid: got %0d/%0d/%b expected 0/0/0", count_o, TRIG_CNT, carry_o); else pass_cnt++;
    START = 32'd50;
    rst_i = 1'b0;
    step();
    total_cnt++; if (count_o !== 32'd50) $display("FAIL rst_release_load: got %0d expected 50", count_o); else pass_cnt++;
    trigger_i = 1'b1;
    for (int i = 0; i < 10; i++) step();
    total_cnt++; if (count_o !== 32'd51 || TRIG_CNT !== 32'd1) $display("FAIL held_trig: got %0d/%0d expected 51/1", count_o, TRIG_CNT); else pass_cnt++;
    release_trig();
  endtask

  task automatic test_random();
    logic [W-1:0] e;
    int           m;
    int           st;
    logic         d;
    m  = int'($urandom_range(0, 1000));
    st = int'($urandom_range(1, 50));
    load(32'(m), 32'(st));
    for (int i = 0; i < 8; i++) begin
      d = 1'($urandom_range(0, 1));
      m = d ? m - st : m + st;
      drive_pulse(d, 32'(m), 1'b0);
      e = exp_q.pop_front(); void'(exp_c_q.pop_front());
      total_cnt++; if (count_o !== e) $display("FAIL rand_count: got %0d expected %0d", $signed(count_o), $signed(e)); else pass_cnt++;
      release_trig();
    end
    total_cnt++; if (TRIG_CNT !== 32'd8) $display("FAIL rand_trig: got %0d expected 8", TRIG_CNT); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_dir();
    test_overflow();
    test_underflow_min_step();
    test_simul_enable();
    test_force_rst();
    test_step_zero();
    test_disable_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
